acc_regfile_stk: RTL and testbench

- Parametrised successor to the 8-bit accumulator register file.
- Holds NREGS general registers, with r0 hardwired to zero, plus one accumulator.
- Adds a hardware accumulator save/restore stack used by call/return and interrupt entry, with full/empty flags and a sticky error flag.
- Sits between decode (acc_ctrl, register addresses, push/pop strobes) and the ALU/memory write-data path, in the same place as the current register file.

---
 rtl/acc_rf_pkg.sv | 20 ++
 rtl/acc_regfile_stk_stack.sv | 89 ++++++++
 rtl/acc_regfile_stk.sv | 103 ++++++++++
 tb/tb_acc_regfile_stk.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/acc_rf_pkg.sv
// acc_rf_pkg: shared definitions for the accumulator register file.
//   - default data width and register count
//   - acc_ctrl operating-mode encodings
package acc_rf_pkg;

  localparam int unsigned ACC_RF_DATA_W = 8;
  localparam int unsigned ACC_RF_NREGS  = 8;

  typedef enum logic [2:0] {
    NOP    = 3'b000,
    ACC_RS = 3'b001,
    ACC_UN = 3'b010,
    CMP    = 3'b011,
    JMP    = 3'b100,
    STM    = 3'b101,
    LDM    = 3'b110,
    LDR    = 3'b111
  } acc_ctrl_e;

endpackage

// File: rtl/acc_regfile_stk_stack.sv
// acc_stack: LIFO of accumulator save slots.
//   clk, rst_n    : clock, asynchronous active-low reset
//   acc_i         : current accumulator value (stored on push / swap)
//   push_i, pop_i : push, pop; both together swap acc with the top slot
//   top_o         : value of the top slot (0 when empty)
//   pop_valid_o   : accumulator should load top_o on this edge
//   full_o/empty_o: stack pointer at DEPTH / at 0
//   err_o         : sticky overflow/underflow, cleared only by reset
module acc_stack #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned SPW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] acc_i,
  input  logic              push_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] top_o,
  output logic              pop_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o
);

  logic [DATA_W-1:0] slot_q [DEPTH];
  logic [DATA_W-1:0] slot_d [DEPTH];
  logic [SPW-1:0]    sp_q, sp_d;
  logic              err_q, err_d;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign err_o   = err_q;

  // Top slot is slot_q[sp-1]; decoded by compare to keep index widths exact.
  always_comb begin
    top_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) top_o = slot_q[i];
    end
  end

  always_comb begin
    slot_d      = slot_q;
    sp_d        = sp_q;
    err_d       = err_q;
    pop_valid_o = 1'b0;
    if (push_i && !pop_i) begin
      if (full_o) begin
        err_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (sp_q == SPW'(i)) slot_d[i] = acc_i;
        end
        sp_d = sp_q + SPW'(1);
      end
    end else if (pop_i && !push_i) begin
      if (empty_o) begin
        err_d = 1'b1;
      end else begin
        sp_d        = sp_q - SPW'(1);
        pop_valid_o = 1'b1;
      end
    end else if (push_i && pop_i) begin
      // Swap: top slot takes acc, acc takes old top, sp unchanged.
      if (empty_o) begin
        err_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (sp_q == SPW'(i + 1)) slot_d[i] = acc_i;
        end
        pop_valid_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '{default: '0};
      sp_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      sp_q   <= sp_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: rtl/acc_regfile_stk.sv
// acc_regfile_stk: general register file (r0 reads 0) plus accumulator
// with a hardware save/restore stack.
//   clk, rst_n      : clock, asynchronous active-low reset
//   wen, acc_ctrl   : write enable and operating mode
//   ra1, ra2        : read addresses (ra1 is also the LDR write address)
//   wd3             : write data for rf (LDR) or acc (other modes)
//   acc_push/pop    : accumulator stack push / pop (both = swap)
//   rd1, rd2        : combinational read data per mode
//   acc_q           : current accumulator
//   stk_full/empty/err : stack flags
module acc_regfile_stk
  import acc_rf_pkg::*;
#(
  parameter  int unsigned DATA_W      = ACC_RF_DATA_W,
  parameter  int unsigned NREGS       = ACC_RF_NREGS,
  parameter  int unsigned STACK_DEPTH = 4,
  localparam int unsigned AW          = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [2:0]        acc_ctrl,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  input  logic [DATA_W-1:0] wd3,
  input  logic              acc_push,
  input  logic              acc_pop,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] acc_q,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_err
);

  acc_ctrl_e         mode;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];
  logic [DATA_W-1:0] acc_d;
  logic [DATA_W-1:0] stk_top;
  logic              stk_pop_valid;
  logic [DATA_W-1:0] rf1, rf2;

  assign mode = acc_ctrl_e'(acc_ctrl);

  acc_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .acc_i       (acc_q),
    .push_i      (acc_push),
    .pop_i       (acc_pop),
    .top_o       (stk_top),
    .pop_valid_o (stk_pop_valid),
    .full_o      (stk_full),
    .empty_o     (stk_empty),
    .err_o       (stk_err)
  );

  always_comb begin
    rf_d = rf_q;
    if (wen && (mode == LDR) && (ra1 != '0)) rf_d[ra1] = wd3;
  end

  // An explicit accumulator write wins over a pop/swap load.
  always_comb begin
    acc_d = acc_q;
    if (stk_pop_valid)        acc_d = stk_top;
    if (wen && (mode != LDR)) acc_d = wd3;
  end

  always_comb begin
    rf1 = (ra1 == '0) ? '0 : rf_q[ra1];
    rf2 = (ra2 == '0) ? '0 : rf_q[ra2];
    rd1 = '0;
    rd2 = '0;
    case (mode)
      ACC_RS: begin
        rd1 = acc_q;
        rd2 = rf2;
      end
      ACC_UN, STM: rd2 = acc_q;
      CMP, JMP: begin
        rd1 = rf1;
        rd2 = rf2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q  <= '{default: '0};
      acc_q <= '0;
    end else begin
      rf_q  <= rf_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: tb/tb_acc_regfile_stk.sv
module tb_acc_regfile_stk;
  import acc_rf_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wen;
  logic [2:0] acc_ctrl;
  logic [2:0] ra1, ra2;
  logic [7:0] wd3;
  logic       acc_push, acc_pop;
  logic [7:0] rd1, rd2, acc_q;
  logic       stk_full, stk_empty, stk_err;

  acc_regfile_stk #(
    .DATA_W      (8),
    .NREGS       (8),
    .STACK_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wen       (wen),
    .acc_ctrl  (acc_ctrl),
    .ra1       (ra1),
    .ra2       (ra2),
    .wd3       (wd3),
    .acc_push  (acc_push),
    .acc_pop   (acc_pop),
    .rd1       (rd1),
    .rd2       (rd2),
    .acc_q     (acc_q),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_err   (stk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] rd1, rd2, acc;
    logic       full, empty, err;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Monitor: outputs are stable at the falling edge; compare against queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (rd1 === e.rd1 && rd2 === e.rd2 && acc_q === e.acc &&
            stk_full === e.full && stk_empty === e.empty && stk_err === e.err)
          n_pass++;
        else
          $display("FAIL %s: got rd1=%h rd2=%h acc=%h full=%b empty=%b err=%b, want rd1=%h rd2=%h acc=%h full=%b empty=%b err=%b",
                   e.name, rd1, rd2, acc_q, stk_full, stk_empty, stk_err,
                   e.rd1, e.rd2, e.acc, e.full, e.empty, e.err);
      end
    end
  end

  task automatic drive(input logic w, input acc_ctrl_e c, input logic [2:0] a1,
                       input logic [2:0] a2, input logic [7:0] d,
                       input logic pu, input logic po);
    wen = w; acc_ctrl = c; ra1 = a1; ra2 = a2; wd3 = d; acc_push = pu; acc_pop = po;
  endtask

  // Queue expected outputs for the current inputs, then advance one edge.
  task automatic cyc(input string nm, input logic [7:0] e1, input logic [7:0] e2,
                     input logic [7:0] ea, input logic ef, input logic ee, input logic er);
    exp_t e;
    e.name = nm; e.rd1 = e1; e.rd2 = e2; e.acc = ea;
    e.full = ef; e.empty = ee; e.err = er;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, CMP, 3, 5, 8'h00, 0, 0);
    #2;
    cyc("reset_state", 8'h00, 8'h00, 8'h00, 0, 1, 0);
    rst_n = 1'b1;
    cyc("post_reset_cmp", 8'h00, 8'h00, 8'h00, 0, 1, 0);

    // Register file writes, r0 protection
    drive(1, LDR, 3, 5, 8'h5A, 0, 0); cyc("ldr_r3_reads0", 8'h00, 8'h00, 8'h00, 0, 1, 0);
    drive(1, LDR, 0, 5, 8'hFF, 0, 0); cyc("ldr_r0", 8'h00, 8'h00, 8'h00, 0, 1, 0);
    drive(0, CMP, 3, 0, 8'h00, 0, 0); cyc("cmp_r3_r0", 8'h5A, 8'h00, 8'h00, 0, 1, 0);
    drive(0, CMP, 0, 3, 8'h00, 0, 0); cyc("cmp_r0_r3", 8'h00, 8'h5A, 8'h00, 0, 1, 0);
    drive(0, JMP, 3, 3, 8'h00, 0, 0); cyc("jmp_r3_r3", 8'h5A, 8'h5A, 8'h00, 0, 1, 0);

    // Basic push/pop
    drive(1, ACC_RS, 0, 3, 8'h11, 0, 0); cyc("acc_wr_11", 8'h00, 8'h5A, 8'h00, 0, 1, 0);
    drive(0, NOP, 0, 0, 8'h00, 1, 0);    cyc("push_11", 8'h00, 8'h00, 8'h11, 0, 1, 0);
    drive(1, ACC_RS, 0, 0, 8'h22, 0, 0); cyc("acc_wr_22", 8'h11, 8'h00, 8'h11, 0, 0, 0);
    drive(0, NOP, 0, 0, 8'h00, 1, 0);    cyc("push_22", 8'h00, 8'h00, 8'h22, 0, 0, 0);
    drive(1, ACC_UN, 0, 0, 8'h33, 0, 0); cyc("acc_un_wr_33", 8'h00, 8'h22, 8'h22, 0, 0, 0);
    drive(0, NOP, 0, 0, 8'h00, 0, 1);    cyc("pop1", 8'h00, 8'h00, 8'h33, 0, 0, 0);
    drive(0, STM, 0, 0, 8'h00, 0, 1);    cyc("stm_after_pop1", 8'h00, 8'h22, 8'h22, 0, 0, 0);
    drive(0, NOP, 0, 0, 8'h00, 0, 0);    cyc("after_pop2", 8'h00, 8'h00, 8'h11, 0, 1, 0);

    // Overflow: push together with acc write
    drive(1, ACC_RS, 0, 0, 8'hA1, 1, 0); cyc("ovf_push1", 8'h11, 8'h00, 8'h11, 0, 1, 0);
    drive(1, ACC_RS, 0, 0, 8'hA2, 1, 0); cyc("ovf_push2", 8'hA1, 8'h00, 8'hA1, 0, 0, 0);
    drive(1, ACC_RS, 0, 0, 8'hA3, 1, 0); cyc("ovf_push3", 8'hA2, 8'h00, 8'hA2, 0, 0, 0);
    drive(1, ACC_RS, 0, 0, 8'hA4, 1, 0); cyc("ovf_push4", 8'hA3, 8'h00, 8'hA3, 0, 0, 0);
    drive(1, ACC_RS, 0, 0, 8'hA5, 1, 0); cyc("ovf_full_push5", 8'hA4, 8'h00, 8'hA4, 1, 0, 0);
    drive(0, NOP, 0, 0, 8'h00, 0, 1);    cyc("ovf_err_pop", 8'h00, 8'h00, 8'hA5, 1, 0, 1);
    cyc("drain_pop2", 8'h00, 8'h00, 8'hA3, 0, 0, 1);
    cyc("drain_pop3", 8'h00, 8'h00, 8'hA2, 0, 0, 1);
    cyc("drain_pop4", 8'h00, 8'h00, 8'hA1, 0, 0, 1);
    cyc("underflow_pop", 8'h00, 8'h00, 8'h11, 0, 1, 1);
    drive(0, NOP, 0, 0, 8'h00, 0, 0);    cyc("after_underflow", 8'h00, 8'h00, 8'h11, 0, 1, 1);

    // Swap and acc-write priority over pop
    drive(1, ACC_RS, 0, 0, 8'hBB, 0, 0); cyc("acc_wr_bb", 8'h11, 8'h00, 8'h11, 0, 1, 1);
    drive(1, ACC_RS, 0, 0, 8'hAA, 1, 0); cyc("push_bb_wr_aa", 8'hBB, 8'h00, 8'hBB, 0, 1, 1);
    drive(0, NOP, 0, 0, 8'h00, 1, 1);    cyc("swap", 8'h00, 8'h00, 8'hAA, 0, 0, 1);
    drive(0, NOP, 0, 0, 8'h00, 0, 1);    cyc("pop_after_swap", 8'h00, 8'h00, 8'hBB, 0, 0, 1);
    drive(0, NOP, 0, 0, 8'h00, 1, 0);    cyc("push_aa", 8'h00, 8'h00, 8'hAA, 0, 1, 1);
    drive(1, ACC_RS, 0, 3, 8'h77, 0, 1); cyc("pop_with_wr_77", 8'hAA, 8'h5A, 8'hAA, 0, 0, 1);
    drive(0, NOP, 0, 0, 8'h00, 1, 1);    cyc("swap_empty", 8'h00, 8'h00, 8'h77, 0, 1, 1);
    drive(0, NOP, 0, 0, 8'h00, 0, 0);    cyc("after_swap_empty", 8'h00, 8'h00, 8'h77, 0, 1, 1);

    // Asynchronous reset in the middle of a push
    drive(1, ACC_RS, 0, 0, 8'h44, 1, 0); cyc("push_77_wr_44", 8'h77, 8'h00, 8'h77, 0, 1, 1);
    drive(0, NOP, 0, 0, 8'h00, 1, 0);    cyc("push_44", 8'h00, 8'h00, 8'h44, 0, 0, 1);
    drive(0, NOP, 0, 0, 8'h00, 1, 0);
    #2;
    rst_n = 1'b0;
    cyc("async_reset_mid_push", 8'h00, 8'h00, 8'h00, 0, 1, 0);
    rst_n = 1'b1;
    drive(0, CMP, 3, 3, 8'h00, 0, 0);    cyc("rf_cleared_r3", 8'h00, 8'h00, 8'h00, 0, 1, 0);
    drive(0, JMP, 7, 5, 8'h00, 0, 0);    cyc("rf_cleared_r7_r5", 8'h00, 8'h00, 8'h00, 0, 1, 0);
    drive(0, NOP, 0, 0, 8'h00, 0, 1);    cyc("pop_after_reset", 8'h00, 8'h00, 8'h00, 0, 1, 0);
    drive(0, NOP, 0, 0, 8'h00, 0, 0);    cyc("err_after_reset_pop", 8'h00, 8'h00, 8'h00, 0, 1, 1);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations still queued, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
